// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared keycodes, screen encoding and monster id type for the game sequencer
package game_pkg;

    localparam logic [7:0] KEY_W         = 8'h1A;
    localparam logic [7:0] KEY_A         = 8'h04;
    localparam logic [7:0] KEY_S         = 8'h16;
    localparam logic [7:0] KEY_D         = 8'h07;
    localparam logic [7:0] KEY_ENTER     = 8'h28;
    localparam logic [7:0] KEY_BACKSPACE = 8'h2A;

    typedef enum logic [2:0] {
        TITLE    = 3'd0,
        SELECT   = 3'd1,
        CONFIRM  = 3'd2,
        START    = 3'd3,
        BATTLE   = 3'd4,
        RESULT   = 3'd5,
        GAMEOVER = 3'd6
    } screen_t;

    typedef logic [2:0] mon_id_t;

endpackage

// File: rtl/key_edge.sv
// rtl/key_edge.sv - turns a held USB keycode level into a single press event
module key_edge (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [7:0] keycode,
    output logic       press,
    output logic [7:0] press_code
);

    logic [7:0] prev_key;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) prev_key <= '0;
        else          prev_key <= keycode;
    end

    assign press      = (keycode != prev_key) && (keycode != 8'h00);
    assign press_code = keycode;

endmodule

// File: rtl/game_control.sv
// rtl/game_control.sv - screen sequencer: team select, battle request, score and lives
module game_control
    import game_pkg::*;
#(
    parameter int NUM_MON = 6,
    parameter int LIVES   = 3
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [7:0]        keycode,
    input  logic              end_battle,
    input  logic              result,
    output logic              is_battle,
    output mon_id_t [1:0]     team,
    output logic [2:0]        screen,
    output logic [2:0]        cursor,
    output logic [1:0]        picked,
    output logic [3:0]        wins,
    output logic [1:0]        lives,
    output logic [3:0]        round
);

    localparam mon_id_t    MAX_ID     = mon_id_t'(NUM_MON - 1);
    localparam logic [1:0] LIVES_INIT = 2'(LIVES);

    screen_t    state;
    logic       press;
    logic [7:0] press_code;

    key_edge u_key_edge (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .keycode    (keycode),
        .press      (press),
        .press_code (press_code)
    );

    logic enter_ev;
    assign enter_ev = press && (press_code == KEY_ENTER);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state  <= TITLE;
            team   <= '0;
            cursor <= '0;
            picked <= '0;
            wins   <= '0;
            round  <= '0;
            lives  <= LIVES_INIT;
        end else begin
            case (state)
                TITLE: if (enter_ev) begin
                    state  <= SELECT;
                    cursor <= '0;
                    picked <= '0;
                    wins   <= '0;
                    round  <= '0;
                    lives  <= LIVES_INIT;
                end
                SELECT: if (press) begin
                    case (press_code)
                        KEY_A: if (cursor != 3'd0) cursor <= cursor - 3'd1;
                        KEY_D: if (cursor != MAX_ID) cursor <= cursor + 3'd1;
                        KEY_ENTER: begin
                            if (picked == 2'b00) begin
                                team[0] <= cursor;
                                picked  <= 2'b01;
                            end else if (cursor != team[0]) begin
                                // second pick must differ from the first
                                team[1] <= cursor;
                                picked  <= 2'b11;
                                state   <= CONFIRM;
                            end
                        end
                        default: ;
                    endcase
                end
                CONFIRM: if (press) begin
                    if (press_code == KEY_ENTER) begin
                        state <= START;
                    end else if (press_code == KEY_BACKSPACE) begin
                        picked <= 2'b00;
                        state  <= SELECT;
                    end
                end
                START: begin
                    state <= BATTLE;
                    if (round != 4'hF) round <= round + 4'd1;
                end
                BATTLE: if (end_battle) begin
                    if (result) begin
                        if (wins != 4'hF) wins <= wins + 4'd1;
                    end else if (lives != 2'd0) begin
                        lives <= lives - 2'd1;
                    end
                    state <= RESULT;
                end
                RESULT: if (enter_ev) state <= (lives == 2'd0) ? GAMEOVER : CONFIRM;
                GAMEOVER: if (enter_ev) state <= TITLE;
                default: state <= TITLE;
            endcase
        end
    end

    assign screen    = state;
    assign is_battle = (state == BATTLE);

endmodule

// File: tb/tb_game_control.sv
// tb/tb_game_control.sv - table-driven directed test of the game sequencer
module tb_game_control;
    import game_pkg::*;

    logic             Clk = 1'b0;
    logic             Reset_n = 1'b0;
    logic [7:0]       keycode = 8'h00;
    logic             end_battle = 1'b0;
    logic             result = 1'b0;
    logic             is_battle;
    logic [1:0][2:0]  team;
    logic [2:0]       screen;
    logic [2:0]       cursor;
    logic [1:0]       picked;
    logic [3:0]       wins;
    logic [1:0]       lives;
    logic [3:0]       round;

    game_control #(.NUM_MON(6), .LIVES(3)) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .keycode    (keycode),
        .end_battle (end_battle),
        .result     (result),
        .is_battle  (is_battle),
        .team       (team),
        .screen     (screen),
        .cursor     (cursor),
        .picked     (picked),
        .wins       (wins),
        .lives      (lives),
        .round      (round)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [7:0] key;
        logic       eb;
        logic       res;
        int         cyc;
        logic [2:0] scr;
        logic [2:0] cur;
        logic [1:0] pk;
        logic [3:0] w;
        logic [1:0] l;
        logic [3:0] r;
        logic       isb;
        logic [1:0] tchk;
        logic [2:0] t0;
        logic [2:0] t1;
    } vec_t;

    vec_t vq[$];
    int total = 0;
    int bad   = 0;

    logic [2:0] e_scr = TITLE;
    logic [2:0] e_cur = 3'd0;
    logic [1:0] e_pk  = 2'b00;
    logic [3:0] e_w   = 4'd0;
    logic [1:0] e_l   = 2'd3;
    logic [3:0] e_r   = 4'd0;
    logic       e_isb = 1'b0;
    logic [1:0] e_tc  = 2'b00;
    logic [2:0] e_t0  = 3'd0;
    logic [2:0] e_t1  = 3'd0;

    task automatic add(input logic [7:0] k, input logic eb, input logic res, input int cyc);
        vec_t v;
        v.key = k; v.eb = eb; v.res = res; v.cyc = cyc;
        v.scr = e_scr; v.cur = e_cur; v.pk = e_pk; v.w = e_w; v.l = e_l; v.r = e_r;
        v.isb = e_isb; v.tchk = e_tc; v.t0 = e_t0; v.t1 = e_t1;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s vec=%0d got=%0d want=%0d", name, idx, act, exp);
        end
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_screen", -1, screen, TITLE);
        chk("rst_is_battle", -1, is_battle, 0);
        chk("rst_lives", -1, lives, 3);
        chk("rst_cursor", -1, cursor, 0);
        chk("rst_picked", -1, picked, 0);
        chk("rst_wins", -1, wins, 0);
        chk("rst_round", -1, round, 0);
        chk("rst_team", -1, team, 0);
        Reset_n = 1'b1;

        // held ENTER gives one TITLE->SELECT transition
        e_scr = SELECT; add(KEY_ENTER, 0, 0, 50);
        add(8'h00, 0, 0, 1);
        add(KEY_A, 0, 0, 1);
        add(KEY_W, 0, 0, 1);
        add(8'h00, 0, 0, 1);
        for (int i = 1; i <= 7; i++) begin
            e_cur = (i > 5) ? 3'd5 : 3'(i);
            add(KEY_D, 0, 0, 1);
            add(8'h00, 0, 0, 1);
        end
        e_pk = 2'b01; e_tc = 2'b01; e_t0 = 3'd5; add(KEY_ENTER, 0, 0, 1);
        add(8'h00, 0, 0, 1);
        add(KEY_ENTER, 0, 0, 1);
        add(8'h00, 0, 0, 1);
        e_cur = 3'd4; add(KEY_A, 0, 0, 1);
        add(8'h00, 0, 0, 1);
        e_scr = CONFIRM; e_pk = 2'b11; e_tc = 2'b11; e_t1 = 3'd4; add(KEY_ENTER, 0, 0, 1);
        add(8'h00, 0, 0, 1);
        add(KEY_S, 0, 0, 1);
        add(8'h00, 0, 0, 1);
        e_scr = SELECT; e_pk = 2'b00; e_tc = 2'b00; add(KEY_BACKSPACE, 0, 0, 1);
        add(8'h00, 0, 0, 1);
        e_pk = 2'b01; e_tc = 2'b01; e_t0 = 3'd4; add(KEY_ENTER, 0, 0, 1);
        add(8'h00, 0, 0, 1);
        e_cur = 3'd5; add(KEY_D, 0, 0, 1);
        add(8'h00, 0, 0, 1);
        e_scr = CONFIRM; e_pk = 2'b11; e_tc = 2'b11; e_t1 = 3'd5; add(KEY_ENTER, 0, 0, 1);
        add(8'h00, 0, 0, 1);
        // START lasts one cycle, then BATTLE with round bumped
        e_scr = START; add(KEY_ENTER, 0, 0, 1);
        e_scr = BATTLE; e_isb = 1'b1; e_r = 4'd1; add(KEY_ENTER, 0, 0, 1);
        add(KEY_ENTER, 0, 0, 3);
        e_scr = RESULT; e_isb = 1'b0; e_w = 4'd1; add(KEY_ENTER, 1, 1, 1);
        add(KEY_ENTER, 0, 0, 5);
        add(8'h00, 0, 0, 1);
        e_scr = CONFIRM; add(KEY_ENTER, 0, 0, 1);
        add(8'h00, 0, 0, 1);
        // three lost battles run lives down to zero
        for (int b = 0; b < 3; b++) begin
            e_scr = START; add(KEY_ENTER, 0, 0, 1);
            e_scr = BATTLE; e_isb = 1'b1; e_r = e_r + 4'd1; add(8'h00, 0, 0, 1);
            e_scr = RESULT; e_isb = 1'b0; e_l = e_l - 2'd1; add(8'h00, 1, 0, 1);
            add(8'h00, 1, 1, 1);
            add(8'h00, 0, 0, 2);
            e_scr = (e_l == 2'd0) ? GAMEOVER : CONFIRM; add(KEY_ENTER, 0, 0, 1);
            add(8'h00, 0, 0, 1);
        end
        e_scr = TITLE; add(KEY_ENTER, 0, 0, 1);
        add(8'h00, 0, 0, 1);
        add(8'h00, 1, 1, 1);
        add(8'h00, 0, 0, 1);
        e_scr = SELECT; e_w = 4'd0; e_r = 4'd0; e_l = 2'd3; e_cur = 3'd0; e_pk = 2'b00; e_tc = 2'b00;
        add(KEY_ENTER, 0, 0, 1);
        add(8'h00, 0, 0, 1);
        e_pk = 2'b01; e_tc = 2'b01; e_t0 = 3'd0; add(KEY_ENTER, 0, 0, 1);
        add(8'h00, 0, 0, 1);
        e_cur = 3'd1; add(KEY_D, 0, 0, 1);
        add(8'h00, 0, 0, 1);
        e_scr = CONFIRM; e_pk = 2'b11; e_tc = 2'b11; e_t1 = 3'd1; add(KEY_ENTER, 0, 0, 1);
        add(8'h00, 0, 0, 1);
        e_scr = START; add(KEY_ENTER, 0, 0, 1);
        e_scr = BATTLE; e_isb = 1'b1; e_r = 4'd1; add(KEY_ENTER, 0, 0, 1);

        foreach (vq[i]) begin
            keycode    = vq[i].key;
            end_battle = vq[i].eb;
            result     = vq[i].res;
            repeat (vq[i].cyc) @(posedge Clk);
            #1;
            end_battle = 1'b0;
            chk("screen", i, screen, vq[i].scr);
            chk("cursor", i, cursor, vq[i].cur);
            chk("picked", i, picked, vq[i].pk);
            chk("wins", i, wins, vq[i].w);
            chk("lives", i, lives, vq[i].l);
            chk("round", i, round, vq[i].r);
            chk("is_battle", i, is_battle, vq[i].isb);
            if (vq[i].tchk[0]) chk("team0", i, team[0], vq[i].t0);
            if (vq[i].tchk[1]) chk("team1", i, team[1], vq[i].t1);
        end

        // asynchronous reset mid-battle drops is_battle before any clock edge
        keycode = 8'h00;
        #2;
        Reset_n = 1'b0;
        #1;
        chk("async_is_battle", -2, is_battle, 0);
        chk("async_screen", -2, screen, TITLE);
        chk("async_round", -2, round, 0);
        #1;
        Reset_n = 1'b1;
        @(posedge Clk); #1;
        end_battle = 1'b1; result = 1'b0;
        @(posedge Clk); #1;
        end_battle = 1'b0;
        chk("title_eb_screen", -3, screen, TITLE);
        chk("title_eb_lives", -3, lives, 3);
        chk("title_eb_is_battle", -3, is_battle, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
